// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory port: FSM states, access sizes
// and the IO region decode.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    LOAD   = 2'd2,
    STORE  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Reserved size 3 is treated as a word.
  function automatic logic [2:0] sz_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic io_hit(input logic [63:0] a, input int sel_hi);
    return a[sel_hi -: 2] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load data assembly: keeps the bytes covered by the access size and fills the
// rest with zero or the replicated sign bit.
module mem_load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int DB = DATA_W / 8;

  int   nb;
  logic fill;

  always_comb begin
    nb     = int'(sz_bytes(size_i));
    fill   = signed_i & raw_i[8*nb-1];
    data_o = '0;
    for (int i = 0; i < DB; i++) begin
      data_o[8*i +: 8] = (i < nb) ? raw_i[8*i +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory port controller: arbitrates ifetch refills and LSB accesses onto the
// 8-bit RAM/IO bus, one byte per cycle.
//
//   state  | meaning
//   IDLE   | bus quiet, waiting for a request (if_req wins over ls_req)
//   IFETCH | reading BLK_BYTES bytes into the refill block
//   LOAD   | reading 1/2/4 bytes for the LSB
//   STORE  | writing 1/2/4 bytes, stalling on a full IO buffer
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BLK_BYTES = 64,
  parameter int IO_SEL_HI = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic [7:0]             mem_din,
  output logic [ADDR_W-1:0]      mem_a,
  output logic                   mem_wr,
  output logic [7:0]             mem_dout,
  input  logic                   io_buffer_full,
  input  logic                   if_req,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic                   if_done,
  output logic [BLK_BYTES*8-1:0] if_blk,
  input  logic                   ls_req,
  input  logic                   ls_store,
  input  logic [ADDR_W-1:0]      ls_addr,
  input  logic [1:0]             ls_size,
  input  logic                   ls_signed,
  input  logic [DATA_W-1:0]      ls_wdata,
  output logic                   ls_done,
  output logic [DATA_W-1:0]      ls_rdata
);

  localparam int CW = $clog2(BLK_BYTES) + 1;
  localparam int DB = DATA_W / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     nbytes_q, nbytes_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ldbuf_q, ldbuf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [7:0]        blk_q [BLK_BYTES];

  logic [ADDR_W-1:0] cur_a;
  logic [CW-1:0]     cap_idx;
  logic              cap_en;
  logic              io_stall;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] ld_raw;
  logic [DATA_W-1:0] ld_ext;

  assign cur_a    = addr_q + ADDR_W'(cnt_q);
  assign cap_idx  = cnt_q - 1'b1;
  assign io_stall = io_hit(64'(cur_a), IO_SEL_HI) & io_buffer_full;
  assign wshift   = wdata_q >> {cnt_q, 3'b000};

  // The final load byte arrives in the same cycle the result is registered,
  // so it is merged straight from mem_din.
  always_comb begin
    ld_raw = ldbuf_q;
    if (cap_en && state_q == LOAD) begin
      for (int i = 0; i < DB; i++) begin
        if (cap_idx == CW'(i)) ld_raw[8*i +: 8] = mem_din;
      end
    end
  end

  mem_load_extend #(.DATA_W(DATA_W)) u_extend (
    .raw_i    (ld_raw),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (ld_ext)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    nbytes_d  = nbytes_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    wdata_d   = wdata_q;
    ldbuf_d   = ldbuf_q;
    rdata_d   = rdata_q;
    if_done_d = 1'b0;
    ls_done_d = 1'b0;
    cap_en    = 1'b0;
    mem_a     = '0;
    mem_wr    = 1'b0;
    mem_dout  = '0;

    case (state_q)
      IDLE: begin
        if (!if_done_q && !ls_done_q && !rollback) begin
          if (if_req) begin
            state_d  = IFETCH;
            addr_d   = if_addr;
            cnt_d    = '0;
            nbytes_d = CW'(BLK_BYTES);
          end else if (ls_req) begin
            state_d  = ls_store ? STORE : LOAD;
            addr_d   = ls_addr;
            cnt_d    = '0;
            nbytes_d = CW'(sz_bytes(ls_size));
            size_d   = ls_size;
            sgn_d    = ls_signed;
            wdata_d  = ls_wdata;
            ldbuf_d  = '0;
          end
        end
      end

      IFETCH, LOAD: begin
        if (cnt_q < nbytes_q) mem_a = cur_a;
        if (rollback) begin
          state_d = IDLE;
        end else begin
          cap_en = (cnt_q != '0);
          if (state_q == LOAD && cap_en) ldbuf_d = ld_raw;
          if (cnt_q == nbytes_q) begin
            state_d = IDLE;
            if (state_q == IFETCH) begin
              if_done_d = 1'b1;
            end else begin
              ls_done_d = 1'b1;
              rdata_d   = ld_ext;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      STORE: begin
        mem_a    = cur_a;
        mem_dout = wshift[7:0];
        if (!io_stall) begin
          mem_wr = 1'b1;
          if (cnt_q == nbytes_q - 1'b1) begin
            state_d   = IDLE;
            ls_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      nbytes_q  <= '0;
      size_q    <= SZ_B;
      sgn_q     <= 1'b0;
      wdata_q   <= '0;
      ldbuf_q   <= '0;
      rdata_q   <= '0;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      for (int i = 0; i < BLK_BYTES; i++) blk_q[i] <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      nbytes_q  <= nbytes_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      wdata_q   <= wdata_d;
      ldbuf_q   <= ldbuf_d;
      rdata_q   <= rdata_d;
      if_done_q <= if_done_d;
      ls_done_q <= ls_done_d;
      if (cap_en && state_q == IFETCH) blk_q[cap_idx[CW-2:0]] <= mem_din;
    end
  end

  always_comb begin
    for (int i = 0; i < BLK_BYTES; i++) if_blk[8*i +: 8] = blk_q[i];
  end

  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a registered byte-RAM model whose
// unwritten locations read back as the low address byte.
module tb_mem_port_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BLK    = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              rollback = 1'b0;
  logic [7:0]        mem_din = 8'h00;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic              io_buffer_full = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_done;
  logic [BLK*8-1:0]  if_blk;
  logic              ls_req = 1'b0;
  logic              ls_store = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [1:0]        ls_size = 2'd0;
  logic              ls_signed = 1'b0;
  logic [DATA_W-1:0] ls_wdata = '0;
  logic              ls_done;
  logic [DATA_W-1:0] ls_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_BYTES(BLK), .IO_SEL_HI(17)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .mem_din(mem_din),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_blk(if_blk),
    .ls_req(ls_req), .ls_store(ls_store), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_signed(ls_signed), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [logic [31:0]];
  logic [31:0] pa = '0;
  logic        pw = 1'b0;
  logic [7:0]  pd = '0;
  logic        pr = 1'b0;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0];
  endfunction

  // Bus is sampled mid-cycle; the RAM acts on the following edge and shares rdy.
  always @(negedge clk) begin
    pa = mem_a; pw = mem_wr; pd = mem_dout; pr = rdy;
  end
  always @(posedge clk) begin
    if (pr) begin
      if (pw) ram[pa] = pd;
      mem_din <= rd(pa);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] exp);
    int n;
    logic [31:0] ea;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    tick();
    ls_req = 1'b1; ls_store = 1'b0; ls_addr = a; ls_size = sz; ls_signed = sg;
    for (int k = 0; k < n; k++) begin
      tick(); mid();
      ea = a + k;
      chk({tag, " mem_a"}, mem_a, ea);
      chk({tag, " early done"}, ls_done, 0);
    end
    tick(); mid();
    chk({tag, " done at N+1"}, ls_done, 0);
    tick(); ls_req = 1'b0; mid();
    chk({tag, " done at N+2"}, ls_done, 1);
    chk({tag, " rdata"}, ls_rdata, exp);
    tick(); mid();
    chk({tag, " done pulse width"}, ls_done, 0);
  endtask

  logic [31:0] ea;
  logic [7:0]  sw_b [4];
  bit          seen;

  initial begin
    ram[32'h20] = 8'h80;
    ram[32'h21] = 8'h7F;

    // reset values
    tick(); tick(); tick(); mid();
    chk("rst mem_a", mem_a, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst mem_dout", mem_dout, 0);
    chk("rst if_done", if_done, 0);
    chk("rst ls_done", ls_done, 0);
    chk("rst ls_rdata", ls_rdata, 0);
    chk("rst if_blk", {63'd0, if_blk == '0}, 1);
    tick(); rst = 1'b0;

    // ifetch refill 0x1000
    tick(); if_req = 1'b1; if_addr = 32'h1000; mid();
    chk("if T mem_a", mem_a, 0);
    for (int k = 0; k < BLK; k++) begin
      tick(); mid();
      ea = 32'h1000 + k;
      if (k == 0 || k == 10 || k == BLK - 1) begin
        chk("if mem_a", mem_a, ea);
        chk("if mem_wr", mem_wr, 0);
      end
      chk("if early done", if_done, 0);
    end
    tick(); mid();
    chk("if T+65 done", if_done, 0);
    chk("if T+65 mem_a", mem_a, 0);
    tick(); if_req = 1'b0; mid();
    chk("if T+66 done", if_done, 1);
    for (int i = 0; i < BLK; i++) chk("if_blk byte", if_blk[8*i +: 8], i);
    tick(); mid();
    chk("if done width", if_done, 0);

    // loads, including address wrap at the top
    do_load("LB signed", 32'h20, 2'd0, 1'b1, 32'hFFFF_FF80);
    do_load("LBU", 32'h20, 2'd0, 1'b0, 32'h0000_0080);
    do_load("LHU", 32'h20, 2'd1, 1'b0, 32'h0000_7F80);
    do_load("LH signed", 32'h1F, 2'd1, 1'b1, 32'hFFFF_801F);
    do_load("LW wrap", 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0100_FFFE);
    do_load("LW sz3", 32'h1000, 2'd3, 1'b1, 32'h0302_0100);

    // SW with rollback mid-store: store must complete
    sw_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    tick(); ls_req = 1'b1; ls_store = 1'b1; ls_addr = 32'h100; ls_size = 2'd2;
    ls_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      tick(); rollback = (k == 1); mid();
      ea = 32'h100 + k;
      chk("SW mem_a", mem_a, ea);
      chk("SW mem_wr", mem_wr, 1);
      chk("SW mem_dout", mem_dout, sw_b[k]);
      chk("SW early done", ls_done, 0);
    end
    tick(); rollback = 1'b0; ls_req = 1'b0; mid();
    chk("SW done T+5", ls_done, 1);
    chk("SW mem_wr after", mem_wr, 0);
    chk("SW rdata kept", ls_rdata, 32'h0302_0100);
    for (int k = 0; k < 4; k++) chk("SW ram", rd(32'h100 + k), sw_b[k]);
    tick(); mid();

    // SB to IO region with back-pressure
    tick(); ls_req = 1'b1; ls_store = 1'b1; ls_addr = 32'h3_0000; ls_size = 2'd0;
    ls_wdata = 32'h0000_00A5;
    for (int k = 0; k < 3; k++) begin
      tick(); io_buffer_full = 1'b1; mid();
      chk("SB io stall wr", mem_wr, 0);
      chk("SB io stall done", ls_done, 0);
    end
    tick(); io_buffer_full = 1'b0; mid();
    chk("SB io write", mem_wr, 1);
    chk("SB io addr", mem_a, 32'h3_0000);
    chk("SB io data", mem_dout, 8'hA5);
    tick(); ls_req = 1'b0; mid();
    chk("SB io done", ls_done, 1);
    chk("SB io ram", rd(32'h3_0000), 8'hA5);
    tick(); mid();

    // simultaneous requests: ifetch first, load accepted right after if_done
    tick(); if_req = 1'b1; if_addr = 32'h2040;
    ls_req = 1'b1; ls_store = 1'b0; ls_addr = 32'h20; ls_size = 2'd0; ls_signed = 1'b0;
    tick(); mid();
    chk("arb ifetch first", mem_a, 32'h2040);
    for (int k = 1; k < 65; k++) begin
      tick(); mid();
    end
    chk("arb no ls_done", ls_done, 0);
    tick(); if_req = 1'b0; mid();
    chk("arb if_done", if_done, 1);
    chk("arb if_blk0", if_blk[7:0], 8'h40);
    tick(); mid();
    chk("arb accept cycle", mem_a, 0);
    tick(); mid();
    chk("arb load addr", mem_a, 32'h20);
    tick(); mid();
    tick(); ls_req = 1'b0; mid();
    chk("arb ls_done", ls_done, 1);
    chk("arb ls_rdata", ls_rdata, 32'h80);
    tick(); mid();

    // rollback at ifetch byte 10
    tick(); if_req = 1'b1; if_addr = 32'h1000;
    for (int k = 0; k < 11; k++) begin
      tick(); rollback = (k == 10); mid();
    end
    chk("rb if byte10 addr", mem_a, 32'h100A);
    tick(); rollback = 1'b0; if_req = 1'b0; mid();
    chk("rb if mem_a", mem_a, 0);
    seen = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tick(); mid();
      if (if_done) seen = 1'b1;
    end
    chk("rb if no done", {63'd0, seen}, 0);

    // rollback coinciding with the final load capture
    tick(); ls_req = 1'b1; ls_store = 1'b0; ls_addr = 32'h20; ls_size = 2'd0; ls_signed = 1'b1;
    tick(); mid();
    tick(); rollback = 1'b1; mid();
    tick(); rollback = 1'b0; ls_req = 1'b0; mid();
    chk("rb ld no done", ls_done, 0);
    chk("rb ld rdata kept", ls_rdata, 32'h80);
    chk("rb ld idle", mem_a, 0);
    tick(); mid();
    chk("rb ld still no done", ls_done, 0);

    // rdy=0 freezes mid-load
    tick(); ls_req = 1'b1; ls_addr = 32'h20; ls_size = 2'd1; ls_signed = 1'b1;
    tick(); mid();
    chk("frz T+1 addr", mem_a, 32'h20);
    for (int k = 0; k < 3; k++) begin
      tick(); rdy = 1'b0; mid();
      chk("frz held addr", mem_a, 32'h21);
      chk("frz no done", ls_done, 0);
    end
    tick(); rdy = 1'b1; mid();
    chk("frz resume addr", mem_a, 32'h21);
    tick(); mid();
    chk("frz no early done", ls_done, 0);
    tick(); ls_req = 1'b0; mid();
    chk("frz done", ls_done, 1);
    chk("frz rdata", ls_rdata, 32'h0000_7F80);
    tick(); mid();

    // reset in the middle of a store
    tick(); ls_req = 1'b1; ls_store = 1'b1; ls_addr = 32'h200; ls_size = 2'd2;
    ls_wdata = 32'h1122_3344;
    tick(); mid();
    chk("rst-op first write", mem_wr, 1);
    tick(); rst = 1'b1; mid();
    tick(); rst = 1'b0; ls_req = 1'b0; mid();
    chk("rst-op mem_wr", mem_wr, 0);
    chk("rst-op mem_a", mem_a, 0);
    chk("rst-op ls_done", ls_done, 0);
    chk("rst-op ls_rdata", ls_rdata, 0);
    chk("rst-op if_blk", {63'd0, if_blk == '0}, 1);
    tick(); mid();
    chk("rst-op no done", ls_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
